// File: rtl/aes_round_key_store.sv
// AES-128 round-key buffer: random-order writes, forward/reverse streamed reads.
// Define AES_RKS_REVERSE_EN to honour dir (decryption order); otherwise streams are forward only.

module aes_rks_entry #(
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [KW-1:0] din,
  output logic [KW-1:0] q
);
  logic [KW-1:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (we) key_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= '0;
    else        key_q <= key_d;
  end

  assign q = key_q;
endmodule

module aes_round_key_store #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [3:0]    wr_idx,
  input  logic [KW-1:0] wr_key,
  input  logic          clear,
  output logic          keys_ready,
  input  logic          start,
  input  logic          dir,
  output logic          busy,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_key,
  output logic          rk_last,
  output logic          wr_err
);
  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [NR:0]       mask_q, mask_d;
  logic              keys_ready_q, keys_ready_d;
  logic              wr_err_q, wr_err_d;
  logic [NR:0]       we;
  logic [NR:0][KW-1:0] mem_q;
  logic [KW-1:0]     key_sel;
  logic              streaming, wr_ok, go, hs, rev, last_w, start_rev;

  assign streaming = (state_q == S_STREAM);
  assign wr_ok     = wr_en && !clear && !streaming && (wr_idx <= LAST);
  assign go        = !streaming && start && keys_ready_q && !clear;
  assign hs        = streaming && rk_ready;

`ifdef AES_RKS_REVERSE_EN
  logic dir_q, dir_d;

  always_comb begin
    dir_d = dir_q;
    if (go) dir_d = dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end

  assign rev       = dir_q;
  assign start_rev = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign rev        = 1'b0;
  assign start_rev  = 1'b0;
`endif

  // One entry per round index; write enables decoded from wr_idx.
  for (genvar i = 0; i <= NR; i++) begin : g_ent
    assign we[i] = wr_ok && (wr_idx == 4'(i));
    aes_rks_entry #(.KW(KW)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[i]),
      .din   (wr_key),
      .q     (mem_q[i])
    );
  end

  always_comb begin
    key_sel = '0;
    for (int i = 0; i <= NR; i++)
      if (ptr_q == 4'(i)) key_sel = mem_q[i];
  end

  assign last_w = rev ? (ptr_q == 4'd0) : (ptr_q == LAST);

  always_comb begin
    mask_d       = clear ? '0 : (mask_q | we);
    keys_ready_d = clear ? 1'b0 : (&mask_q);
    wr_err_d     = wr_en && ((wr_idx > LAST) || streaming);
  end

  // clear wins over start and over the handshake advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (go) begin
          state_d = S_STREAM;
          ptr_d   = start_rev ? LAST : 4'd0;
        end
        S_STREAM: if (hs) begin
          if (last_w) state_d = S_IDLE;
          else        ptr_d   = rev ? (ptr_q - 4'd1) : (ptr_q + 4'd1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= 4'd0;
      mask_q       <= '0;
      keys_ready_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mask_q       <= mask_d;
      keys_ready_q <= keys_ready_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign keys_ready = keys_ready_q;
  assign wr_err     = wr_err_q;
  assign busy       = streaming;
  assign rk_valid   = streaming;
  assign rk_idx     = streaming ? ptr_q : 4'd0;
  assign rk_key     = streaming ? key_sel : '0;
  assign rk_last    = streaming && last_w;
endmodule
